// File: rtl/bg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bg_pkg - shared background geometry, index type and wrap helper      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bg_pkg;

  localparam int BG_W     = 320;
  localparam int BG_H     = 240;
  localparam int ADDR_W   = 17;
  localparam int SCROLL_W = 9;

  typedef logic [3:0] bg_idx_t;

  localparam bg_idx_t BG_SKY_IDX = 4'h0;

  // Both operands are below BG_W, so one conditional subtract is a full modulo.
  function automatic logic [9:0] wrap_add(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] s;
    s = a + b;
    if (s >= 10'(BG_W)) s = s - 10'(BG_W);
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bg_valid_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bg_valid_delay - DEPTH-stage valid shift register, cleared by Reset  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bg_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bg_index_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bg_index_fetch - raster position to background ROM index, scrolled   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bg_index_fetch
  import bg_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic                scroll_en,
  input  logic [3:0]          scroll_step,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                active,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [3:0]          rom_data,
  output logic [3:0]          bg_index,
  output logic                bg_valid,
  output logic [SCROLL_W-1:0] scroll_x
);

  logic [SCROLL_W-1:0] r_scroll_x;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_v1;
  bg_idx_t             r_bg_index;
  logic                r_bg_valid;

  logic [9:0]          w_hx;
  logic [9:0]          w_sx;
  logic [8:0]          w_sy;
  logic [ADDR_W-1:0]   w_row;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_v_aligned;

  // Source image is pixel-doubled, so halve the raster coordinates.
  assign w_hx = DrawX >> 1;
  assign w_sy = 9'(DrawY >> 1);
  assign w_sx = wrap_add(w_hx, 10'(r_scroll_x));

  generate
    if (BG_W == 320) begin : g_row_shift
      assign w_row = (ADDR_W'(w_sy) << 8) + (ADDR_W'(w_sy) << 6);
    end else begin : g_row_mult
      assign w_row = ADDR_W'(ADDR_W'(w_sy) * ADDR_W'(BG_W));
    end
  endgenerate

  assign w_addr = w_row + ADDR_W'(w_sx);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_scroll_x <= '0;
    end else if (frame_start && scroll_en) begin
      r_scroll_x <= SCROLL_W'(wrap_add(10'(r_scroll_x), 10'(scroll_step)));
    end
  end

  // Address stage holds during blanking so the ROM address bus stays quiet.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rom_addr <= '0;
      r_v1       <= 1'b0;
    end else begin
      if (active) r_rom_addr <= w_addr;
      r_v1 <= active;
    end
  end

  bg_valid_delay #(
    .DEPTH (ROM_LAT)
  ) u_vdelay (
    .Clk   (Clk),
    .Reset (Reset),
    .i_d   (r_v1),
    .o_q   (w_v_aligned)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bg_index <= BG_SKY_IDX;
      r_bg_valid <= 1'b0;
    end else begin
      r_bg_index <= w_v_aligned ? rom_data : BG_SKY_IDX;
      r_bg_valid <= w_v_aligned;
    end
  end

  assign rom_addr = r_rom_addr;
  assign bg_index = r_bg_index;
  assign bg_valid = r_bg_valid;
  assign scroll_x = r_scroll_x;

endmodule
`default_nettype wire
